tse_1000bx_rx_sync_fsm: RTL and testbench

//  IEEE 802.3 Clause 36 receive synchronization FSM for the 1000BASE-X/SGMII PCS.
//  - Sits between the GXB rx word-aligner outputs and the PCS receive path.
//  - Qualifies 8b/10b-decoded code-groups, tracks even/odd alignment and drives sync_status (link).
//  - Forwards each code-group with 1-cycle latency, aligned to its status.

---
 rtl/tse_1000bx_rx_sync_fsm_pkg.sv | 22 ++
 rtl/tse_1000bx_rx_sync_fsm_if.sv | 34 +++
 rtl/tse_1000bx_rx_sync_fsm_classify.sv | 23 ++
 rtl/tse_1000bx_rx_sync_fsm.sv | 156 +++++++++++++++
 tb/tb_tse_1000bx_rx_sync_fsm.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tse_1000bx_rx_sync_fsm_pkg.sv
// Shared types and constants for the 1000BASE-X receive synchronization FSM.
// Holds the Clause 36 sync state encoding and the well-known idle code-group values.
package tse_rx_sync_pkg;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        CD1, CD2, CD3,
        AS1, AS2,
        SA1, SA2, SA3, SA4
    } sync_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;

    localparam int GOOD_CGS_MAX_DEFAULT = 3;

    function automatic logic is_sync_acq(input sync_state_e s);
        return s inside {SA1, SA2, SA3, SA4};
    endfunction

endpackage

// File: rtl/tse_1000bx_rx_sync_fsm_if.sv
// Code-group stream from the word aligner into the sync FSM, plus the
// registered PCS-side view and statistics coming back out.
interface tse_1000bx_rx_sync_fsm_if #(
    parameter int STAT_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_frame;
    logic              rx_kchar;
    logic              rx_char_err;
    logic              rx_disp_err;
    logic              stats_clr;

    logic [7:0]        pcs_rx_frame;
    logic              pcs_rx_kchar;
    logic              pcs_rx_err;
    logic              rx_even;
    logic              sync_status;
    logic              los_pulse;
    logic [STAT_W-1:0] los_cnt;
    logic [STAT_W-1:0] cgbad_cnt;

    modport master (
        output rx_valid, rx_frame, rx_kchar, rx_char_err, rx_disp_err, stats_clr,
        input  pcs_rx_frame, pcs_rx_kchar, pcs_rx_err, rx_even, sync_status,
               los_pulse, los_cnt, cgbad_cnt
    );

    modport slave (
        input  rx_valid, rx_frame, rx_kchar, rx_char_err, rx_disp_err, stats_clr,
        output pcs_rx_frame, pcs_rx_kchar, pcs_rx_err, rx_even, sync_status,
               los_pulse, los_cnt, cgbad_cnt
    );

endinterface

// File: rtl/tse_1000bx_rx_sync_fsm_classify.sv
// Combinational code-group qualifier: flags commas and decides whether the
// current code-group is good, given the slot it would occupy without realignment.
module tse_rx_cg_classify
    import tse_rx_sync_pkg::*;
#(
    parameter logic [7:0] COMMA_CODE = K28_5
) (
    input  logic [7:0] rx_frame_i,
    input  logic       rx_kchar_i,
    input  logic       rx_char_err_i,
    input  logic       rx_disp_err_i,
    input  logic       even_slot_i,
    output logic       comma_o,
    output logic       cgbad_o,
    output logic       cggood_o
);

    assign comma_o  = rx_kchar_i & (rx_frame_i == COMMA_CODE);
    // A comma landing in the odd slot means the alignment has slipped.
    assign cgbad_o  = rx_char_err_i | rx_disp_err_i | (comma_o & ~even_slot_i);
    assign cggood_o = ~cgbad_o;

endmodule

// File: rtl/tse_1000bx_rx_sync_fsm.sv
// Clause 36 receive synchronization FSM with 1-cycle registered code-group forwarding.
// Define TSE_RX_SYNC_STATS_EN to build the saturating los/cgbad statistics counters.
module tse_1000bx_rx_sync_fsm
    import tse_rx_sync_pkg::*;
#(
    parameter int         GOOD_CGS_MAX = GOOD_CGS_MAX_DEFAULT,
    parameter logic [7:0] COMMA_CODE   = K28_5,
    parameter int         STAT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_rx_clk,
    tse_1000bx_rx_sync_fsm_if.slave rx_if
);

    localparam int GCW = $clog2(GOOD_CGS_MAX + 1);

    sync_state_e    state_q, state_d;
    logic [GCW-1:0] good_cgs_q, good_cgs_d;
    logic           slot_q, slot_d, slot_now;
    logic           comma, cgbad, cggood;
    logic           sync_d, los_d;
    logic [7:0]     frame_q;
    logic           kchar_q, err_q, sync_q, los_q;

    // Slot the current code-group occupies if no comma realigns it.
    assign slot_now = ~slot_q;

    tse_rx_cg_classify #(.COMMA_CODE(COMMA_CODE)) u_classify (
        .rx_frame_i   (rx_if.rx_frame),
        .rx_kchar_i   (rx_if.rx_kchar),
        .rx_char_err_i(rx_if.rx_char_err),
        .rx_disp_err_i(rx_if.rx_disp_err),
        .even_slot_i  (slot_now),
        .comma_o      (comma),
        .cgbad_o      (cgbad),
        .cggood_o     (cggood)
    );

    always_ff @(posedge clk or posedge reset_rx_clk) begin
        if (reset_rx_clk) begin
            state_q    <= LOSS_OF_SYNC;
            good_cgs_q <= '0;
        end else if (rx_if.rx_valid) begin
            state_q    <= state_d;
            good_cgs_q <= good_cgs_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        good_cgs_d = '0;
        case (state_q)
            LOSS_OF_SYNC: if (comma) state_d = CD1;
            CD1, CD2, CD3: begin
                if (!rx_if.rx_kchar && cggood) begin
                    case (state_q)
                        CD1:     state_d = AS1;
                        CD2:     state_d = AS2;
                        default: state_d = SA1;
                    endcase
                end else begin
                    state_d = LOSS_OF_SYNC;
                end
            end
            AS1, AS2: begin
                if (cgbad)      state_d = LOSS_OF_SYNC;
                else if (comma) state_d = (state_q == AS1) ? CD2 : CD3;
            end
            SA1, SA2, SA3, SA4: begin
                if (cgbad) begin
                    case (state_q)
                        SA1:     state_d = SA2;
                        SA2:     state_d = SA3;
                        SA3:     state_d = SA4;
                        default: state_d = LOSS_OF_SYNC;
                    endcase
                end else if (state_q != SA1) begin
                    if (int'(good_cgs_q) + 1 >= GOOD_CGS_MAX) begin
                        case (state_q)
                            SA2:     state_d = SA1;
                            SA3:     state_d = SA2;
                            default: state_d = SA3;
                        endcase
                    end else begin
                        good_cgs_d = good_cgs_q + GCW'(1);
                    end
                end
            end
            default: state_d = LOSS_OF_SYNC;
        endcase
    end

    always_comb begin
        slot_d = comma | slot_now;
        sync_d = is_sync_acq(state_d);
        los_d  = rx_if.rx_valid & is_sync_acq(state_q) & (state_d == LOSS_OF_SYNC);
    end

    always_ff @(posedge clk or posedge reset_rx_clk) begin
        if (reset_rx_clk) begin
            frame_q <= '0;
            kchar_q <= 1'b0;
            err_q   <= 1'b0;
            slot_q  <= 1'b0;
            sync_q  <= 1'b0;
            los_q   <= 1'b0;
        end else begin
            // los_q follows los_d every cycle so an idle strobe never stretches the pulse.
            los_q <= los_d;
            if (rx_if.rx_valid) begin
                frame_q <= rx_if.rx_frame;
                kchar_q <= rx_if.rx_kchar;
                err_q   <= cgbad;
                slot_q  <= slot_d;
                sync_q  <= sync_d;
            end
        end
    end

    assign rx_if.pcs_rx_frame = frame_q;
    assign rx_if.pcs_rx_kchar = kchar_q;
    assign rx_if.pcs_rx_err   = err_q;
    assign rx_if.rx_even      = slot_q;
    assign rx_if.sync_status  = sync_q;
    assign rx_if.los_pulse    = los_q;

`ifdef TSE_RX_SYNC_STATS_EN
    logic [STAT_W-1:0] los_cnt_q, cgbad_cnt_q;

    always_ff @(posedge clk or posedge reset_rx_clk) begin
        if (reset_rx_clk) begin
            los_cnt_q   <= '0;
            cgbad_cnt_q <= '0;
        end else if (rx_if.stats_clr) begin
            los_cnt_q   <= '0;
            cgbad_cnt_q <= '0;
        end else begin
            if (los_d && !(&los_cnt_q))
                los_cnt_q <= los_cnt_q + STAT_W'(1);
            if (rx_if.rx_valid && cgbad && !(&cgbad_cnt_q))
                cgbad_cnt_q <= cgbad_cnt_q + STAT_W'(1);
        end
    end

    assign rx_if.los_cnt   = los_cnt_q;
    assign rx_if.cgbad_cnt = cgbad_cnt_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = rx_if.stats_clr;
    assign rx_if.los_cnt    = {STAT_W{1'b0}};
    assign rx_if.cgbad_cnt  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_tse_1000bx_rx_sync_fsm.sv
// Self-checking bench for tse_1000bx_rx_sync_fsm: hand-derived vector tables
// plus reset and counter-saturation sequences, compared through a scoreboard queue.
module tb_tse_1000bx_rx_sync_fsm;
    import tse_rx_sync_pkg::*;

    localparam int STAT_W = 8;   // narrow counters so saturation is reachable quickly

    typedef struct {
        logic       v;
        logic [7:0] f;
        logic       k;
        logic       ce;
        logic       de;
        logic       clr;
        logic       e_sync;
        logic       e_even;
        logic       e_err;
        logic       e_los;
    } vec_t;

    typedef struct {
        logic [7:0]        frame;
        logic              kchar;
        logic              err;
        logic              even;
        logic              sync;
        logic              los;
        logic [STAT_W-1:0] lcnt;
        logic [STAT_W-1:0] ccnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_rx_clk = 1'b1;
    always #5 clk = ~clk;

    tse_1000bx_rx_sync_fsm_if #(.STAT_W(STAT_W)) rx_if ();

    tse_1000bx_rx_sync_fsm #(.STAT_W(STAT_W)) dut (
        .clk         (clk),
        .reset_rx_clk(reset_rx_clk),
        .rx_if       (rx_if)
    );

    int                errors = 0;
    int                checks = 0;
    vec_t              tbl_a[$];
    vec_t              tbl_b[$];
    exp_t              sb[$];
    logic [7:0]        last_f;
    logic              last_k;
    logic [STAT_W-1:0] exp_c;
    logic [STAT_W-1:0] exp_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] f, input logic k,
                                input logic ce, input logic de, input logic s,
                                input logic e, input logic r, input logic l);
        vec_t x;
        x.v = v; x.f = f; x.k = k; x.ce = ce; x.de = de; x.clr = 1'b0;
        x.e_sync = s; x.e_even = e; x.e_err = r; x.e_los = l;
        return x;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".frame"}, 32'(rx_if.pcs_rx_frame), 0);
        check({tag, ".kchar"}, 32'(rx_if.pcs_rx_kchar), 0);
        check({tag, ".err"},   32'(rx_if.pcs_rx_err),   0);
        check({tag, ".even"},  32'(rx_if.rx_even),      0);
        check({tag, ".sync"},  32'(rx_if.sync_status),  0);
        check({tag, ".los"},   32'(rx_if.los_pulse),    0);
        check({tag, ".lcnt"},  32'(rx_if.los_cnt),      0);
        check({tag, ".ccnt"},  32'(rx_if.cgbad_cnt),    0);
    endtask

    // Drives one vector, queues its expectation, then compares after the consuming edge.
    task automatic apply(input string tag, input int idx, input vec_t x);
        exp_t  e;
        string n;
        @(negedge clk);
        rx_if.rx_valid    = x.v;
        rx_if.rx_frame    = x.f;
        rx_if.rx_kchar    = x.k;
        rx_if.rx_char_err = x.ce;
        rx_if.rx_disp_err = x.de;
        rx_if.stats_clr   = x.clr;
        if (x.v) begin
            last_f = x.f;
            last_k = x.k;
        end
`ifdef TSE_RX_SYNC_STATS_EN
        if (x.clr) begin
            exp_c = '0;
            exp_l = '0;
        end else begin
            if (x.v && x.e_err && exp_c != '1) exp_c = exp_c + 1'b1;
            if (x.e_los && exp_l != '1)        exp_l = exp_l + 1'b1;
        end
`endif
        e.frame = last_f; e.kchar = last_k; e.err = x.e_err; e.even = x.e_even;
        e.sync = x.e_sync; e.los = x.e_los; e.lcnt = exp_l; e.ccnt = exp_c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n = $sformatf("%s[%0d]", tag, idx);
        check({n, ".frame"}, 32'(rx_if.pcs_rx_frame), 32'(e.frame));
        check({n, ".kchar"}, 32'(rx_if.pcs_rx_kchar), 32'(e.kchar));
        check({n, ".err"},   32'(rx_if.pcs_rx_err),   32'(e.err));
        check({n, ".even"},  32'(rx_if.rx_even),      32'(e.even));
        check({n, ".sync"},  32'(rx_if.sync_status),  32'(e.sync));
        check({n, ".los"},   32'(rx_if.los_pulse),    32'(e.los));
        check({n, ".lcnt"},  32'(rx_if.los_cnt),      32'(e.lcnt));
        check({n, ".ccnt"},  32'(rx_if.cgbad_cnt),    32'(e.ccnt));
    endtask

    // Asserts reset part-way through a cycle, checks the asynchronous clear, then
    // holds reset under random inputs before releasing it.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset_rx_clk = 1'b1;
        #1;
        check_zero({tag, "_async"});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_if.rx_valid    = 1'($urandom);
            rx_if.rx_frame    = 8'($urandom);
            rx_if.rx_kchar    = 1'($urandom);
            rx_if.rx_char_err = 1'($urandom);
            rx_if.rx_disp_err = 1'($urandom);
            rx_if.stats_clr   = 1'($urandom);
            @(posedge clk);
            #1;
            check_zero($sformatf("%s_hold%0d", tag, i));
        end
        @(negedge clk);
        reset_rx_clk      = 1'b0;
        rx_if.rx_valid    = 1'b0;
        rx_if.stats_clr   = 1'b0;
        last_f = '0;
        last_k = 1'b0;
        exp_c  = '0;
        exp_l  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t x;

        // Acquisition from reset on the K28.5/D16.2 idle stream.
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 1, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));
        // Four bad code-groups: SA2, SA3, SA4, loss; pulse does not stretch over an idle strobe.
        tbl_a.push_back(mk(1, K28_5, 1, 1, 0, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 1, 0, 1, 0, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 1, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 1, 0, 0, 0, 1, 1));
        tbl_a.push_back(mk(0, K28_5, 1, 1, 0, 0, 0, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));
        // Three bad (SA4), six good (SA3 then SA2), then three bad must lose sync.
        tbl_a.push_back(mk(1, K28_5, 1, 1, 0, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 1, 0, 1, 0, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 1, 0, 1, 1, 1, 0));
        for (int i = 0; i < 3; i++) begin
            tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));
            tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 1, 1, 0, 0));
        end
        tbl_a.push_back(mk(1, D16_2, 0, 1, 0, 1, 0, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 1, 0, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 1, 0, 0, 1, 1));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));
        // Back-to-back K28.5: each one after the first lands in the odd slot.
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 1, 1, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 1, 1, 1, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 1, 1));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 1, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, K28_5, 1, 0, 0, 0, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));
        tbl_a.push_back(mk(1, D5_6,  0, 0, 0, 1, 1, 0, 0));
        tbl_a.push_back(mk(1, D16_2, 0, 0, 0, 1, 0, 0, 0));

        // Acquisition with rx_valid low every other cycle; junk on the idle strobes.
        for (int i = 0; i < 7; i++) begin
            logic ev;
            logic sy;
            ev = (i % 2 == 0);
            sy = (i >= 5);
            tbl_b.push_back(mk(1, ev ? K28_5 : D16_2, ev, 0, 0, sy, ev, 0, 0));
            tbl_b.push_back(mk(0, K28_5, 1, 1, 1, sy, ev, 0, 0));
        end

        rx_if.rx_valid = 1'b0; rx_if.rx_frame = '0; rx_if.rx_kchar = 1'b0;
        rx_if.rx_char_err = 1'b0; rx_if.rx_disp_err = 1'b0; rx_if.stats_clr = 1'b0;

        do_reset("rst0");
        foreach (tbl_a[i]) apply("tbl_a", i, tbl_a[i]);

        do_reset("rst_mid");
        foreach (tbl_b[i]) apply("tbl_b", i, tbl_b[i]);

        // Bad data code-groups in LOSS_OF_SYNC drive cgbad_cnt into saturation.
        do_reset("rst_sat");
        for (int i = 0; i < 260; i++)
            apply("sat", i, mk(1, D16_2, 0, 1, 0, 0, (i % 2 == 0), 1, 0));
        check("sat.final", 32'(rx_if.cgbad_cnt), 32'(exp_c));
        x = mk(1, D16_2, 0, 1, 0, 0, 1, 1, 0);
        x.clr = 1'b1;
        apply("clr_wins", 0, x);
        apply("after_clr", 0, mk(1, D16_2, 0, 1, 0, 0, 0, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
